// File: rtl/rv16_pipe_adder_unit.sv
// rv16_pipe_adder_unit: slice-pipelined adder/subtractor.
// Stage k adds bit slice k using the carry registered by stage k-1. The
// operands and the finished lower result bits ride along with each beat.
// The whole pipeline advances together, gated by the output handshake.
// The last stage register drives the outputs directly, so a stalled result
// holds stable without any extra storage.
// Optional feature: define RV16_ADDER_SAT_EN to clamp signed overflow to
// the most positive or most negative value. DATA must be a multiple of STAGES.
module rv16_pipe_adder_unit #(
  parameter int DATA   = 16,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DATA-1:0] rs1_add_in,
  input  logic [DATA-1:0] rs2_add_in,
  input  logic            rp_cin,
  input  logic            sub_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] rd_add_out,
  output logic            rp_cout,
  output logic            ovf_out,
  output logic            zero_out
);

  localparam int W    = DATA / STAGES;
  localparam int LAST = STAGES - 1;

  logic            advance;
  logic [DATA-1:0] b_eff;
  logic            cin_eff;
  logic [DATA-1:0] res_wrap;
  logic            a_msb;
  logic            b_msb;
  logic            ovf;

  // Subtraction is A + ~B + 1; rp_cin only matters in add mode.
  assign b_eff   = sub_en ? ~rs2_add_in : rs2_add_in;
  assign cin_eff = sub_en ? 1'b1 : rp_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic            vld;
    logic            c;
    logic [DATA-1:0] a;
    logic [DATA-1:0] b;
    logic [DATA-1:0] sum;

    logic            src_v;
    logic            src_c;
    logic [DATA-1:0] src_a;
    logic [DATA-1:0] src_b;
    logic [DATA-1:0] src_sum;
    logic [DATA-1:0] sum_nxt;
    logic [W:0]      slice;

    if (k == 0) begin : g_first
      assign src_v   = in_valid;
      assign src_c   = cin_eff;
      assign src_a   = rs1_add_in;
      assign src_b   = b_eff;
      assign src_sum = '0;
    end else begin : g_next
      assign src_v   = g_stage[k-1].vld;
      assign src_c   = g_stage[k-1].c;
      assign src_a   = g_stage[k-1].a;
      assign src_b   = g_stage[k-1].b;
      assign src_sum = g_stage[k-1].sum;
    end

    assign slice = {1'b0, src_a[k*W +: W]} + {1'b0, src_b[k*W +: W]} + {{W{1'b0}}, src_c};

    // Insert this stage's slice into the partial result carried by the beat.
    always_comb begin
      sum_nxt = src_sum;
      sum_nxt[k*W +: W] = slice[W-1:0];
    end

    // Stage register: moves only when the whole pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
        c   <= 1'b0;
        a   <= '0;
        b   <= '0;
        sum <= '0;
      end else if (advance) begin
        vld <= src_v;
        c   <= slice[W];
        a   <= src_a;
        b   <= src_b;
        sum <= sum_nxt;
      end
    end
  end

  assign out_valid = g_stage[LAST].vld;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  assign res_wrap = g_stage[LAST].sum;
  assign a_msb    = g_stage[LAST].a[DATA-1];
  assign b_msb    = g_stage[LAST].b[DATA-1];
  assign ovf      = (a_msb == b_msb) && (res_wrap[DATA-1] != a_msb);

`ifdef RV16_ADDER_SAT_EN
  // Both operands negative clamps to 100..0; both positive clamps to 011..1.
  assign rd_add_out = ovf ? {a_msb, {(DATA-1){~a_msb}}} : res_wrap;
`else
  assign rd_add_out = res_wrap;
`endif

  assign rp_cout  = g_stage[LAST].c;
  assign ovf_out  = ovf;
  // Gated by valid so the all-zero reset state does not report zero.
  assign zero_out = out_valid && (rd_add_out == '0);

endmodule

// File: tb/tb_rv16_pipe_adder_unit.sv
// Directed bench for rv16_pipe_adder_unit at DATA=16, STAGES=4.
module tb_rv16_pipe_adder_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] rs1_add_in;
  logic [15:0] rs2_add_in;
  logic        rp_cin;
  logic        sub_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] rd_add_out;
  logic        rp_cout;
  logic        ovf_out;
  logic        zero_out;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-computed table: a = 0x0101*i, b = 0x0011, add, cin 0.
  logic [15:0] tbl_a [8];
  logic [15:0] tbl_rd [8];

  rv16_pipe_adder_unit #(.DATA(16), .STAGES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rs1_add_in (rs1_add_in),
    .rs2_add_in (rs2_add_in),
    .rp_cin     (rp_cin),
    .sub_en     (sub_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rd_add_out (rd_add_out),
    .rp_cout    (rp_cout),
    .ovf_out    (ovf_out),
    .zero_out   (zero_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          input logic [15:0] e_rd, input logic e_c, input logic e_ovf,
                          input logic e_z);
    int lat;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    rs1_add_in = a;
    rs2_add_in = b;
    rp_cin     = cin;
    sub_en     = sub;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check_eq({tag, "_lat"}, lat, 4);
    check_eq({tag, "_rd"}, rd_add_out, e_rd);
    check_eq({tag, "_cout"}, rp_cout, e_c);
    check_eq({tag, "_ovf"}, ovf_out, e_ovf);
    check_eq({tag, "_zero"}, zero_out, e_z);
  endtask

  initial begin
    int tx;
    int rx;
    logic acc;

    tbl_a[0] = 16'h0000; tbl_rd[0] = 16'h0011;
    tbl_a[1] = 16'h0101; tbl_rd[1] = 16'h0112;
    tbl_a[2] = 16'h0202; tbl_rd[2] = 16'h0213;
    tbl_a[3] = 16'h0303; tbl_rd[3] = 16'h0314;
    tbl_a[4] = 16'h0404; tbl_rd[4] = 16'h0415;
    tbl_a[5] = 16'h0505; tbl_rd[5] = 16'h0516;
    tbl_a[6] = 16'h0606; tbl_rd[6] = 16'h0617;
    tbl_a[7] = 16'h0707; tbl_rd[7] = 16'h0718;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rs1_add_in = 16'h0;
    rs2_add_in = 16'h0;
    rp_cin = 1'b0;
    sub_en = 1'b0;
    step();
    step();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_rd", rd_add_out, 0);
    check_eq("rst_cout", rp_cout, 0);
    check_eq("rst_ovf", ovf_out, 0);
    check_eq("rst_zero", zero_out, 0);
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready", in_ready, 1);
    idle(2);

    send_one("add_cin", 16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0, 1'b0);
    send_one("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef RV16_ADDER_SAT_EN
    send_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
    send_one("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
`else
    send_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    send_one("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
`endif
    send_one("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    send_one("sub_eq", 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    send_one("sub_cin_ign", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Back-to-back: 8 beats, results expected on cycles 4..11.
    rs2_add_in = 16'h0011;
    rp_cin = 1'b0;
    sub_en = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 13; cyc++) begin
      if (cyc < 8) begin
        in_valid = 1'b1;
        rs1_add_in = tbl_a[cyc];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc < 8) check_eq("b2b_in_ready", in_ready, 1);
      if (cyc >= 4 && cyc < 12) begin
        check_eq("b2b_valid", out_valid, 1);
        check_eq("b2b_rd", rd_add_out, tbl_rd[cyc-4]);
      end else begin
        check_eq("b2b_idle_valid", out_valid, 0);
      end
      step();
    end
    idle(3);

    // Backpressure: out_ready low on cycles 4..6 with beats in flight.
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      if (tx < 6) begin
        in_valid = 1'b1;
        rs1_add_in = tbl_a[tx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        check_eq("bp_stall_valid", out_valid, 1);
        check_eq("bp_stall_in_ready", in_ready, 0);
        check_eq("bp_stall_rd", rd_add_out, tbl_rd[0]);
        check_eq("bp_stall_cout", rp_cout, 0);
      end
      if (out_valid && out_ready) begin
        if (rx < 6) check_eq("bp_rd", rd_add_out, tbl_rd[rx]);
        else check_eq("bp_extra_beat", rx, 5);
        rx++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) tx++;
    end
    check_eq("bp_count", rx, 6);
    idle(2);

    // Reset with 3 beats in flight.
    for (int cyc = 0; cyc < 3; cyc++) begin
      in_valid = 1'b1;
      rs1_add_in = tbl_a[cyc];
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rpulse_valid", out_valid, 0);
    check_eq("rpulse_rd", rd_add_out, 0);
    step();
    check_eq("rpulse_hold_valid", out_valid, 0);
    rst_n = 1'b1;
    #1;
    check_eq("rpulse_in_ready", in_ready, 1);
    for (int cyc = 0; cyc < 8; cyc++) begin
      step();
      check_eq("rpulse_after_valid", out_valid, 0);
    end
    send_one("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("post_rst_alone", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
